// File: rtl/audio_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : audio_level_meter
// Brief    : Pipelined N-channel level meter: mix/select, rectify, envelope,
//            peak-hold, sticky clip and log-scaled bar/dot LED display.
// Revision : 1.0
// ============================================================================
module audio_level_meter #(
    parameter int DATA_WIDTH   = 18,
    parameter int NCH          = 2,
    parameter int NLEDS        = 8,
    parameter int DECAY_SHIFT  = 10,
    parameter int HOLD_SAMPLES = 24000,
    localparam int c_SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_data_en,
    input  logic [NCH*DATA_WIDTH-1:0] i_ch_data,
    input  logic [1:0]                i_mode,
    input  logic [c_SEL_W-1:0]        i_ch_sel,
    input  logic                      i_clear,
    output logic [NLEDS-1:0]          o_leds,
    output logic [DATA_WIDTH-2:0]     o_peak_level,
    output logic                      o_clip,
    output logic                      o_level_valid
);

    localparam int c_LOG2N  = (NCH > 1) ? $clog2(NCH) : 0;
    localparam int c_SUM_W  = DATA_WIDTH + c_LOG2N;
    localparam int c_MAG_W  = DATA_WIDTH - 1;
    localparam int c_HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam logic [c_HOLD_W-1:0]   c_HOLD_INIT = c_HOLD_W'(HOLD_SAMPLES);
    localparam logic [DATA_WIDTH-1:0] c_POS_FS    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_NEG_FS    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] w_ch [NCH];
    logic signed [c_SUM_W-1:0]    w_sum;
    logic signed [DATA_WIDTH-1:0] w_sel;
    logic signed [DATA_WIDTH-1:0] w_mix;
    logic                         w_clip_hit;

    logic                         r_s1_valid;
    logic signed [DATA_WIDTH-1:0] r_s1_mix;
    logic                         r_s1_clip;
    logic                         r_s1_dot;

    logic [c_MAG_W-1:0]           w_mag;
    logic                         r_s2_valid;
    logic [c_MAG_W-1:0]           r_s2_mag;
    logic                         r_s2_clip;
    logic                         r_s2_dot;

    logic [c_MAG_W-1:0]           w_env_dec;
    logic [c_MAG_W-1:0]           w_env_nxt;
    logic [c_MAG_W-1:0]           r_env;
    logic [c_MAG_W-1:0]           r_peak;
    logic [c_HOLD_W-1:0]          r_hold;
    logic                         r_clip;
    logic                         r_s3_valid;
    logic                         r_s3_dot;

    logic [NLEDS-1:0]             w_env_th;
    logic [NLEDS-1:0]             w_pk_th;
    logic                         r_s4_valid;
    logic [NLEDS-1:0]             r_s4_env_th;
    logic [NLEDS-1:0]             r_s4_pk_th;
    logic [c_MAG_W-1:0]           r_s4_peak;
    logic                         r_s4_clip;
    logic                         r_s4_dot;

    logic [NLEDS-1:0]             w_env_top;
    logic [NLEDS-1:0]             w_pk_top;
    logic [NLEDS-1:0]             w_leds_nxt;
    logic [NLEDS-1:0]             r_leds;
    logic [c_MAG_W-1:0]           r_peak_level;
    logic                         r_clip_out;
    logic                         r_level_valid;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            assign w_ch[i] = i_ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Out-of-range channel selects fall back to channel 0 via the default.
    always_comb begin
        w_sum      = '0;
        w_sel      = w_ch[0];
        w_clip_hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_sum = w_sum + c_SUM_W'(w_ch[i]);
            if (int'(i_ch_sel) == i) begin
                w_sel = w_ch[i];
            end
            if ((w_ch[i] == c_POS_FS) || (w_ch[i] == c_NEG_FS)) begin
                w_clip_hit = 1'b1;
            end
        end
        w_mix = i_mode[1] ? w_sel : DATA_WIDTH'(w_sum >>> c_LOG2N);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mix   <= '0;
            r_s1_clip  <= 1'b0;
            r_s1_dot   <= 1'b0;
        end else begin
            r_s1_valid <= i_data_en & ~i_clear;
            if (i_data_en && !i_clear) begin
                r_s1_mix  <= w_mix;
                r_s1_clip <= w_clip_hit;
                r_s1_dot  <= i_mode[0];
            end
        end
    end

    // Most-negative input saturates to the largest positive magnitude.
    assign w_mag = (r_s1_mix == c_NEG_FS) ? {c_MAG_W{1'b1}} :
                   r_s1_mix[DATA_WIDTH-1] ? c_MAG_W'(-r_s1_mix) :
                                            r_s1_mix[c_MAG_W-1:0];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_clip  <= 1'b0;
            r_s2_dot   <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid & ~i_clear;
            if (r_s1_valid) begin
                r_s2_mag  <= w_mag;
                r_s2_clip <= r_s1_clip;
                r_s2_dot  <= r_s1_dot;
            end
        end
    end

    assign w_env_dec = r_env - (r_env >> DECAY_SHIFT);
    assign w_env_nxt = (r_s2_mag > r_env) ? r_s2_mag : w_env_dec;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_env      <= '0;
            r_peak     <= '0;
            r_hold     <= '0;
            r_clip     <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_dot   <= 1'b0;
        end else if (i_clear) begin
            r_env      <= '0;
            r_peak     <= '0;
            r_hold     <= '0;
            r_clip     <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_env    <= w_env_nxt;
                r_clip   <= r_clip | r_s2_clip;
                r_s3_dot <= r_s2_dot;
                if (r_s2_mag >= r_peak) begin
                    r_peak <= r_s2_mag;
                    r_hold <= c_HOLD_INIT;
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - c_HOLD_W'(1);
                end else begin
                    r_peak <= w_env_nxt;
                end
            end
        end
    end

    // One threshold per LED, 6 dB apart, topmost at half of full scale.
    generate
        for (genvar k = 0; k < NLEDS; k++) begin : g_thr
            localparam logic [c_MAG_W-1:0] c_THR = c_MAG_W'(1) << (DATA_WIDTH - 1 - NLEDS + k);
            assign w_env_th[k] = (r_env  >= c_THR);
            assign w_pk_th[k]  = (r_peak >= c_THR);
        end
    endgenerate

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s4_valid  <= 1'b0;
            r_s4_env_th <= '0;
            r_s4_pk_th  <= '0;
            r_s4_peak   <= '0;
            r_s4_clip   <= 1'b0;
            r_s4_dot    <= 1'b0;
        end else begin
            r_s4_valid <= r_s3_valid & ~i_clear;
            if (r_s3_valid) begin
                r_s4_env_th <= w_env_th;
                r_s4_pk_th  <= w_pk_th;
                r_s4_peak   <= r_peak;
                r_s4_clip   <= r_clip;
                r_s4_dot    <= r_s3_dot;
            end
        end
    end

    // Thresholds are monotonic, so the top lit bit is where the thermometer ends.
    assign w_env_top  = r_s4_env_th & ~(r_s4_env_th >> 1);
    assign w_pk_top   = r_s4_pk_th  & ~(r_s4_pk_th  >> 1);
    assign w_leds_nxt = r_s4_dot ? (w_env_top | w_pk_top) : (r_s4_env_th | w_pk_top);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_leds        <= '0;
            r_peak_level  <= '0;
            r_clip_out    <= 1'b0;
            r_level_valid <= 1'b0;
        end else if (i_clear) begin
            r_leds        <= '0;
            r_peak_level  <= '0;
            r_clip_out    <= 1'b0;
            r_level_valid <= 1'b0;
        end else begin
            r_level_valid <= r_s4_valid;
            if (r_s4_valid) begin
                r_leds       <= w_leds_nxt;
                r_peak_level <= r_s4_peak;
                r_clip_out   <= r_s4_clip;
            end
        end
    end

    assign o_leds        = r_leds;
    assign o_peak_level  = r_peak_level;
    assign o_clip        = r_clip_out;
    assign o_level_valid = r_level_valid;

endmodule
`default_nettype wire

// File: tb/tb_audio_level_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_audio_level_meter
// Brief    : Directed and randomized self-checking bench for audio_level_meter.
// Revision : 1.0
// ============================================================================
module tb_audio_level_meter;

    localparam int W     = 18;
    localparam int NCH   = 2;
    localparam int NL    = 8;
    localparam int DS    = 10;
    localparam int HOLD  = 4;
    localparam int LOG2N = 1;
    localparam int FSMAX = (1 << (W-1)) - 1;

    logic              clk;
    logic              i_reset_n;
    logic              i_data_en;
    logic [NCH*W-1:0]  i_ch_data;
    logic [1:0]        i_mode;
    logic [0:0]        i_ch_sel;
    logic              i_clear;
    logic [NL-1:0]     o_leds;
    logic [W-2:0]      o_peak_level;
    logic              o_clip;
    logic              o_level_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int m_env, m_peak, m_hold;
    bit m_clip;

    typedef struct {
        int            stamp;
        logic [NL-1:0] leds;
        int            peak;
        bit            clip;
    } exp_t;
    exp_t exp_q[$];

    audio_level_meter #(
        .DATA_WIDTH   (W),
        .NCH          (NCH),
        .NLEDS        (NL),
        .DECAY_SHIFT  (DS),
        .HOLD_SAMPLES (HOLD)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (i_reset_n),
        .i_data_en     (i_data_en),
        .i_ch_data     (i_ch_data),
        .i_mode        (i_mode),
        .i_ch_sel      (i_ch_sel),
        .i_clear       (i_clear),
        .o_leds        (o_leds),
        .o_peak_level  (o_peak_level),
        .o_clip        (o_clip),
        .o_level_valid (o_level_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NCH*W-1:0] pack2(input int l, input int r);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = l[W-1:0];
        b = r[W-1:0];
        return {b, a};
    endfunction

    function automatic int smp(input logic [NCH*W-1:0] d, input int i);
        logic signed [W-1:0] t;
        t = d[i*W +: W];
        return int'(t);
    endfunction

    task automatic model_clear();
        m_env = 0; m_peak = 0; m_hold = 0; m_clip = 0;
    endtask

    // Reference: integer arithmetic straight from the meter's rules.
    task automatic model_sample(input logic [NCH*W-1:0] d, input logic [1:0] md, input int sel,
                                output logic [NL-1:0] el, output int ep, output bit ec);
        int s, v, mix, mag, etop, ptop, thr;
        bit hit;
        s = 0; hit = 0;
        for (int i = 0; i < NCH; i++) begin
            v = smp(d, i);
            s += v;
            if (v == FSMAX || v == -FSMAX - 1) hit = 1;
        end
        mix = s >>> LOG2N;
        if (md[1]) mix = smp(d, (sel < NCH) ? sel : 0);
        mag = (mix < 0) ? -mix : mix;
        if (mag > FSMAX) mag = FSMAX;
        if (mag > m_env) m_env = mag;
        else m_env = m_env - (m_env >> DS);
        if (mag >= m_peak) begin
            m_peak = mag; m_hold = HOLD;
        end else if (m_hold != 0) begin
            m_hold = m_hold - 1;
        end else begin
            m_peak = m_env;
        end
        m_clip = m_clip | hit;
        etop = -1; ptop = -1;
        for (int k = 0; k < NL; k++) begin
            thr = 1 << (W - 1 - NL + k);
            if (m_env >= thr) etop = k;
            if (m_peak >= thr) ptop = k;
        end
        el = '0;
        if (!md[0]) begin
            for (int k = 0; k <= etop; k++) el[k] = 1'b1;
        end else if (etop >= 0) begin
            el[etop] = 1'b1;
        end
        if (ptop >= 0) el[ptop] = 1'b1;
        ep = m_peak;
        ec = m_clip;
    endtask

    task automatic send_sample(input logic [NCH*W-1:0] d, input logic [1:0] md, input logic sel,
                               output bit lat_ok, output logic [NL-1:0] l,
                               output logic [W-2:0] p, output logic c);
        @(negedge clk);
        i_ch_data = d; i_mode = md; i_ch_sel = sel; i_data_en = 1'b1;
        @(posedge clk); #1;
        i_data_en = 1'b0;
        lat_ok = 1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e < 4 && o_level_valid) lat_ok = 0;
            if (e == 4) begin
                if (!o_level_valid) lat_ok = 0;
                l = o_leds; p = o_peak_level; c = o_clip;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_data_en = 1'b0; i_clear = 1'b0;
        i_ch_data = '0; i_mode = 2'b00; i_ch_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_leds !== '0) begin n_fail++; $display("FAIL reset_leds got=%h exp=0", o_leds); end
        n_checks++; if (o_peak_level !== '0) begin n_fail++; $display("FAIL reset_peak got=%0d exp=0", o_peak_level); end
        n_checks++; if (o_clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip got=%b exp=0", o_clip); end
        n_checks++; if (o_level_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_level_valid); end
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_scale_mix();
        bit ok; logic [NL-1:0] l; logic [W-2:0] p; logic c;
        send_sample(pack2(70000, 70000), 2'b00, 1'b0, ok, l, p, c);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mix_latency got=bad exp=valid_after_4_edges"); end
        n_checks++; if (l !== 8'hFF) begin n_fail++; $display("FAIL mix_leds got=%h exp=ff", l); end
        n_checks++; if (p !== 17'd70000) begin n_fail++; $display("FAIL mix_peak got=%0d exp=70000", p); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL mix_clip got=%b exp=0", c); end
    endtask

    task automatic test_cancel();
        bit ok; logic [NL-1:0] l; logic [W-2:0] p; logic c;
        do_clear();
        send_sample(pack2(70000, -70000), 2'b00, 1'b0, ok, l, p, c);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL cancel_latency got=bad exp=valid"); end
        n_checks++; if (l !== 8'h00) begin n_fail++; $display("FAIL cancel_leds got=%h exp=00", l); end
        n_checks++; if (p !== 17'd0) begin n_fail++; $display("FAIL cancel_peak got=%0d exp=0", p); end
    endtask

    task automatic test_peak_hold();
        bit ok; logic [NL-1:0] l; logic [W-2:0] p; logic c;
        do_clear();
        send_sample(pack2(65536, 65536), 2'b00, 1'b0, ok, l, p, c);
        n_checks++; if (l !== 8'hFF) begin n_fail++; $display("FAIL hold_first_leds got=%h exp=ff", l); end
        for (int j = 1; j <= 5; j++) begin
            send_sample(pack2(0, 0), 2'b00, 1'b0, ok, l, p, c);
            n_checks++;
            if (l[7] !== (j <= 4)) begin
                n_fail++; $display("FAIL hold_led7_zero%0d got=%b exp=%b", j, l[7], (j <= 4));
            end
            if (j <= 4) begin
                n_checks++;
                if (p !== 17'd65536) begin n_fail++; $display("FAIL hold_peak_zero%0d got=%0d exp=65536", j, p); end
            end
        end
    endtask

    task automatic test_clip_select();
        bit ok; logic [NL-1:0] l; logic [W-2:0] p; logic c;
        do_clear();
        send_sample(pack2(-131072, 0), 2'b10, 1'b0, ok, l, p, c);
        n_checks++; if (l !== 8'hFF) begin n_fail++; $display("FAIL clipsel_leds got=%h exp=ff", l); end
        n_checks++; if (p !== 17'd131071) begin n_fail++; $display("FAIL clipsel_peak got=%0d exp=131071", p); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL clipsel_clip got=%b exp=1", c); end
        send_sample(pack2(0, 0), 2'b10, 1'b0, ok, l, p, c);
        send_sample(pack2(0, 0), 2'b10, 1'b0, ok, l, p, c);
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL clip_sticky got=%b exp=1", c); end
        do_clear();
        n_checks++; if (o_clip !== 1'b0) begin n_fail++; $display("FAIL clear_clip got=%b exp=0", o_clip); end
        n_checks++; if (o_leds !== '0) begin n_fail++; $display("FAIL clear_leds got=%h exp=0", o_leds); end
        n_checks++; if (o_peak_level !== '0) begin n_fail++; $display("FAIL clear_peak got=%0d exp=0", o_peak_level); end
    endtask

    task automatic test_dot();
        bit ok; logic [NL-1:0] l; logic [W-2:0] p; logic c;
        do_clear();
        send_sample(pack2(3000, 3000), 2'b01, 1'b0, ok, l, p, c);
        n_checks++; if (l !== 8'b0000_0100) begin n_fail++; $display("FAIL dot_leds got=%b exp=00000100", l); end
        n_checks++; if (p !== 17'd3000) begin n_fail++; $display("FAIL dot_peak got=%0d exp=3000", p); end
    endtask

    task automatic test_abort();
        bit ok; logic [NL-1:0] l; logic [W-2:0] p; logic c; bit seen;
        send_sample(pack2(70000, 70000), 2'b00, 1'b0, ok, l, p, c);
        @(negedge clk);
        i_ch_data = pack2(90000, 90000); i_mode = 2'b00; i_data_en = 1'b1;
        @(posedge clk); #1;
        i_data_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        i_reset_n = 1'b0;
        #1;
        n_checks++; if (o_leds !== '0) begin n_fail++; $display("FAIL areset_leds got=%h exp=0", o_leds); end
        n_checks++; if (o_peak_level !== '0) begin n_fail++; $display("FAIL areset_peak got=%0d exp=0", o_peak_level); end
        n_checks++; if (o_level_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", o_level_valid); end
        @(negedge clk);
        i_reset_n = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (o_level_valid) seen = 1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL areset_no_valid got=1 exp=0"); end
        @(negedge clk);
        i_ch_data = pack2(50000, 50000); i_data_en = 1'b1; i_clear = 1'b1;
        @(posedge clk); #1;
        i_data_en = 1'b0; i_clear = 1'b0;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (o_level_valid) seen = 1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL clear_with_en got=valid exp=none"); end
        @(negedge clk);
        i_data_en = 1'b1;
        @(posedge clk); #1;
        i_data_en = 1'b0;
        @(posedge clk); #1;
        do_clear();
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (o_level_valid) seen = 1; end
        n_checks++; if (seen) begin n_fail++; $display("FAIL clear_inflight got=valid exp=none"); end
        n_checks++; if (o_leds !== '0) begin n_fail++; $display("FAIL clear_inflight_leds got=%h exp=0", o_leds); end
    endtask

    task automatic test_back_to_back();
        int cyc; int l, r; logic [1:0] md; logic sel; bit en, clr;
        logic [NCH*W-1:0] d; exp_t e;
        do_clear();
        model_clear();
        exp_q.delete();
        cyc = 0;
        for (int it = 0; it < 420; it++) begin
            @(negedge clk);
            en  = (it < 400) && ($urandom_range(0, 9) < 7);
            clr = (it < 400) && ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 7))
                0:       l = FSMAX;
                1:       l = -FSMAX - 1;
                2:       l = $urandom_range(0, 4000) - 2000;
                default: l = int'($urandom_range(0, 2*FSMAX + 1)) - FSMAX - 1;
            endcase
            case ($urandom_range(0, 7))
                0:       r = FSMAX;
                1:       r = 0;
                default: r = int'($urandom_range(0, 2*FSMAX + 1)) - FSMAX - 1;
            endcase
            d   = pack2(l, r);
            md  = 2'($urandom_range(0, 3));
            sel = 1'($urandom_range(0, 1));
            i_ch_data = d; i_mode = md; i_ch_sel = sel; i_data_en = en; i_clear = clr;
            @(posedge clk);
            cyc++;
            if (clr) begin
                model_clear();
                exp_q.delete();
            end else if (en) begin
                model_sample(d, md, int'(sel), e.leds, e.peak, e.clip);
                e.stamp = cyc + 4;
                exp_q.push_back(e);
            end
            #1;
            if (o_level_valid) begin
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
                    n_fail++; $display("FAIL b2b_unexpected_valid cycle=%0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++; if (o_leds !== e.leds) begin n_fail++; $display("FAIL b2b_leds cycle=%0d got=%b exp=%b", cyc, o_leds, e.leds); end
                    n_checks++; if (int'(o_peak_level) != e.peak) begin n_fail++; $display("FAIL b2b_peak cycle=%0d got=%0d exp=%0d", cyc, o_peak_level, e.peak); end
                    n_checks++; if (o_clip !== e.clip) begin n_fail++; $display("FAIL b2b_clip cycle=%0d got=%b exp=%b", cyc, o_clip, e.clip); end
                end
            end else if (exp_q.size() != 0 && exp_q[0].stamp == cyc) begin
                n_checks++; n_fail++;
                $display("FAIL b2b_missing_valid cycle=%0d got=0 exp=1", cyc);
                void'(exp_q.pop_front());
            end
        end
        i_data_en = 1'b0; i_clear = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_scale_mix();
        test_cancel();
        test_peak_hold();
        test_clip_select();
        test_dot();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_level_meter.md
Name: audio_level_meter

Overview:
Parametrised multi-channel audio level meter driving the board LEDs. It generalises the fixed combinational mono-mix/rectify/LED-slice display into a pipelined meter with:
- N-channel mixing or single-channel selection
- saturating rectification
- an instant-attack / exponential-decay envelope
- a peak-hold timer
- a sticky clip flag
- log-scaled (6 dB per LED) bar or dot display

It sits between the LM4550 controller sample outputs (qualified by DIN_RDY) and ld7..ld0. It also exposes peak and clip status for an ioports16V2018 input port.

Parameters:
DATA_WIDTH, 18, sample width (two's complement).
NCH, 2, number of channels; must be a power of 2 (1, 2, 4, 8).
NLEDS, 8, number of LED outputs; 1 <= NLEDS <= DATA_WIDTH-1.
DECAY_SHIFT, 10, envelope decay per sample: env -= env>>DECAY_SHIFT.
HOLD_SAMPLES, 24000, peak-hold duration in samples (0.5 s at 48 kHz).

Ports:
clock  in  1  master clock (BIT_CLK, 12.288 MHz), rising edge.
reset_n  in  1  asynchronous reset, active low.
data_en  in  1  sample strobe, one-cycle pulse (DIN_RDY).
ch_data  in  NCH*DATA_WIDTH  channel samples; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
mode  in  2  mode[0]: 0=bar, 1=dot; mode[1]: 0=mix all channels, 1=selected channel only.
ch_sel  in  max(1,clog2(NCH))  channel index used when mode[1]=1.
clear  in  1  synchronous clear of envelope, peak, hold counter and clip.
leds  out  NLEDS  LED drive, 1=lit; leds[NLEDS-1] is loudest.
peak_level  out  DATA_WIDTH-1  held peak magnitude.
clip  out  1  sticky full-scale detect.
level_valid  out  1  one-cycle pulse when leds and peak_level have updated.

Behaviour:
- Reset (reset_n=0, asynchronous): all pipeline valids, env, peak, hold_cnt, clip, leds, peak_level and level_valid go to 0 immediately.
- Pipeline: four stages, fully pipelined; back-to-back data_en is accepted.
- S1, at the edge sampling data_en=1:
  - mix = (sum of all channels, sign-extended by clog2(NCH) bits) >>> clog2(NCH); selected channel if mode[1]=1.
  - ch_sel >= NCH selects channel 0.
  - clip_hit = any channel equals +max (2^(W-1)-1) or -max-1 (-2^(W-1)), regardless of mode.
- S2: mag = |mix|, saturating: -2^(W-1) maps to 2^(W-1)-1. mag is unsigned, W-1 bits.
- S3, state update:
  - Envelope: if mag > env then env <= mag, else env <= env - (env>>DECAY_SHIFT).
  - Peak: if mag >= peak then peak <= mag and hold_cnt <= HOLD_SAMPLES.
  - Otherwise, if hold_cnt != 0, hold_cnt <= hold_cnt-1 and peak unchanged.
  - Otherwise peak <= new env value.
  - clip <= clip | clip_hit.
- S4:
  - Threshold T_k = 2^(W-1-NLEDS+k), k = 0..NLEDS-1. With W=18, NLEDS=8: T0=512, T7=65536.
  - top(x) = highest k with x >= T_k; none if x < T0.
  - Bar mode: leds[k] = (env >= T_k), OR'd with a single lit bit at top(peak).
  - Dot mode: only bits top(env) and top(peak) lit.
  - peak_level <= peak; level_valid pulses high.
- Latency: level_valid is high in the cycle after the 4th rising edge following the edge that sampled data_en=1. leds, peak_level and clip hold their values between updates.
- Decay underflow: decay never goes below 0. Once env >> DECAY_SHIFT == 0, env holds its residual value until a larger sample arrives or clear is asserted.
- clear:
  - On the next edge, zeroes env, peak, hold_cnt, clip, leds, peak_level and all pipeline valids.
  - A data_en coincident with clear is discarded.
  - Any in-flight samples are discarded; no level_valid follows.
- Mode or ch_sel change: applies to samples captured from the next S1. env and peak are not reset.
- hold_cnt counts samples (data_en events), not clocks, and never wraps.

Test Plan:
1. W=18, NCH=2, NLEDS=8. Hold reset_n=0, then release; pulse data_en with L=R=70000 in mix/bar mode -> level_valid exactly 4 edges later; leds=8'hFF; peak_level=70000; clip=0.
2. L=70000, R=-70000 after a clear -> mix=0; leds=8'h00; peak_level=0.
3. Bar mode, HOLD_SAMPLES=4, one sample L=R=65536, then zeros:
   - env steps 65536 -> 65472 -> ..., so env alone drops below T7 after the first zero sample.
   - leds[7] stays lit through 4 zero samples because peak is held.
   - On the 5th zero sample peak follows env and leds[7]=0.
4. mode=2'b10, ch_sel=0, L=-131072 -> mag=131071; leds=8'hFF; clip=1. clip remains 1 after further quiet samples; clear -> clip=0, leds=0, peak_level=0.
5. Dot mode, fresh state, single sample L=R=3000 -> leds=8'b0000_0100 (T2=2048 <= 3000 < 4096).
6. Assert reset_n=0 asynchronously two cycles after data_en -> all outputs 0 before the next edge; no level_valid afterwards. Also assert clear together with data_en -> no level_valid.
